// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the two requester ports, their grant/read-return
// strobes and the shared memory port into one interface.
// The master modport is the requester/memory side; the slave modport is the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  // Requester port 0 (core) and port 1 (secondary master)
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  // Shared memory port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
    output mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between port 0 (core) and
// port 1 (display/DMA). Grants are combinational, ownership is sticky for up
// to MAX_BURST consecutive grants while the other port waits, then rotates.
// Read data returns one cycle after the grant with a per-port valid strobe.
module mem_arbiter #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.slave  bus
);

  // Owner of the memory port in the previous cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

  owner_e     prev_r;
  owner_e     prev_n_s;
  logic       last_r;     // 1'b0 = port 0 granted last, 1'b1 = port 1
  logic       last_n_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_n_s;
  logic       rd_pend0_r;
  logic       rd_pend1_r;
  logic       rd_pend0_n_s;
  logic       rd_pend1_n_s;
  logic       gnt0_s;
  logic       gnt1_s;
  logic       cap_hit_s;

  assign cap_hit_s = (cnt_r >= MAX_CNT);

  // Grant selection; forced off while reset is asserted so nothing reaches memory
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (!reset_n) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (bus.req0 && !bus.req1) begin
      gnt0_s = 1'b1;
    end else if (!bus.req0 && bus.req1) begin
      gnt1_s = 1'b1;
    end else if (bus.req0 && bus.req1) begin
      case (prev_r)
        OWN_P0: begin
          if (cap_hit_s) begin
            gnt1_s = 1'b1;
          end else begin
            gnt0_s = 1'b1;
          end
        end
        OWN_P1: begin
          if (cap_hit_s) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        OWN_NONE: begin
          // Fresh contention: the port that was not served last goes first
          if (last_r) begin
            gnt0_s = 1'b1;
          end else begin
            gnt1_s = 1'b1;
          end
        end
        default: begin
          gnt0_s = 1'b0;
          gnt1_s = 1'b0;
        end
      endcase
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  // Next-state for owner tracking, burst counter and pending-read flags
  always_comb begin
    prev_n_s     = OWN_NONE;
    last_n_s     = last_r;
    cnt_n_s      = 4'd0;
    rd_pend0_n_s = 1'b0;
    rd_pend1_n_s = 1'b0;
    if (gnt0_s) begin
      prev_n_s     = OWN_P0;
      last_n_s     = 1'b0;
      rd_pend0_n_s = !bus.we0;
      if (prev_r == OWN_P0) begin
        cnt_n_s = cap_hit_s ? MAX_CNT : (cnt_r + 4'd1);
      end else begin
        cnt_n_s = 4'd1;
      end
    end else if (gnt1_s) begin
      prev_n_s     = OWN_P1;
      last_n_s     = 1'b1;
      rd_pend1_n_s = !bus.we1;
      if (prev_r == OWN_P1) begin
        cnt_n_s = cap_hit_s ? MAX_CNT : (cnt_r + 4'd1);
      end else begin
        cnt_n_s = 4'd1;
      end
    end else begin
      // Idle cycle breaks any burst
      prev_n_s = OWN_NONE;
      cnt_n_s  = 4'd0;
    end
  end

  // State register; reset drops any read granted in the cycle reset arrives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_r     <= OWN_NONE;
      last_r     <= 1'b1;
      cnt_r      <= 4'd0;
      rd_pend0_r <= 1'b0;
      rd_pend1_r <= 1'b0;
    end else begin
      prev_r     <= prev_n_s;
      last_r     <= last_n_s;
      cnt_r      <= cnt_n_s;
      rd_pend0_r <= rd_pend0_n_s;
      rd_pend1_r <= rd_pend1_n_s;
    end
  end

  // Memory-side mux: the granted port drives the bus, otherwise all zero
  always_comb begin
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    if (gnt0_s) begin
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
      bus.mem_we    = bus.we0;
    end else if (gnt1_s) begin
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
      bus.mem_we    = bus.we1;
    end else begin
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
      bus.mem_we    = 1'b0;
    end
  end

  assign bus.gnt0    = gnt0_s;
  assign bus.gnt1    = gnt1_s;
  assign bus.rvalid0 = rd_pend0_r;
  assign bus.rvalid1 = rd_pend1_r;
  // Read data is shared; each port qualifies it with its own rvalid
  assign bus.rdata0  = bus.mem_rdata;
  assign bus.rdata1  = bus.mem_rdata;

endmodule
